shadow_framebuffer: RTL and testbench

- Receiving end of the pixel-plot interface (plot, x, y, colour) that the game top drives into the VGA adapter.
- Keeps a readable on-chip copy of every pixel written, so game logic (snake self-collision, food placement) can look up the colour at any coordinate.
- Sits beside vga_adapter on the same plot bus.
- Provides a registered read port with a ready/valid handshake and a clear sweep.

---
 rtl/snake_pkg.sv | 21 ++
 rtl/fb_ram.sv | 39 +++
 rtl/shadow_framebuffer.sv | 149 ++++++++++++++
 tb/tb_shadow_framebuffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
//   SCREEN_W / SCREEN_H : playfield size in pixels
//   COLOUR_W            : bits per pixel on the plot bus
//   BLACK / RED / GREEN : colour codes used by the game
//   fb_state_e          : shadow framebuffer sweep/run state
package snake_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

    typedef enum logic {
        CLEAR,
        RUN
    } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port,
// registered read data. Written to infer block RAM.
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable (read register holds when low)
//   raddr_i : read address
//   rdata_o : registered read data (old data on same-address collision)
module fb_ram #(
    parameter int unsigned DEPTH  = 19200,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/shadow_framebuffer.sv
// Shadow framebuffer: readable on-chip copy of every pixel plotted to the
// VGA adapter, so game logic can look up the colour at any coordinate.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   clear / busy         : restart the background sweep / sweep in progress
//   plot, x, y, colour   : pixel write strobe and data (same bus as vga_adapter)
//   wr_dropped           : pulse, a write was discarded (out of range or sweeping)
//   rd_req, rd_x, rd_y   : read request and coordinate, taken when rd_ready
//   rd_ready             : !busy
//   rd_valid             : pulse one cycle after an accepted read
//   rd_colour, rd_oob    : read result, held until the next rd_valid
module shadow_framebuffer
    import snake_pkg::*;
#(
    parameter int unsigned            WIDTH       = SCREEN_W,
    parameter int unsigned            HEIGHT      = SCREEN_H,
    parameter int unsigned            COLOUR_BITS = COLOUR_W,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR   = COLOUR_BITS'(BLACK)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   plot,
    input  logic [7:0]             x,
    input  logic [6:0]             y,
    input  logic [COLOUR_BITS-1:0] colour,
    output logic                   wr_dropped,
    input  logic                   rd_req,
    input  logic [7:0]             rd_x,
    input  logic [6:0]             rd_y,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [COLOUR_BITS-1:0] rd_colour,
    output logic                   rd_oob
);

    localparam int unsigned DEPTH  = WIDTH * HEIGHT;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // y*WIDTH + x; the 160-column case is two shifts and adds.
    function automatic logic [ADDR_W-1:0] xy_addr(input logic [7:0] cx,
                                                  input logic [6:0] cy);
        if (WIDTH == 160) begin
            return ADDR_W'({cy, 7'b0}) + ADDR_W'({cy, 5'b0}) + ADDR_W'(cx);
        end else begin
            return ADDR_W'(cy) * ADDR_W'(WIDTH) + ADDR_W'(cx);
        end
    endfunction

    function automatic logic in_range(input logic [7:0] cx,
                                      input logic [6:0] cy);
        return (32'(cx) < WIDTH) && (32'(cy) < HEIGHT);
    endfunction

    fb_state_e               state_q;
    logic [ADDR_W-1:0]       clr_addr_q;
    logic                    wr_dropped_q;
    logic                    rd_valid_q;
    logic                    rd_oob_q;
    logic                    byp_q;
    logic [COLOUR_BITS-1:0]  byp_data_q;

    logic                    wr_en;
    logic                    rd_accept;
    logic                    rd_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_waddr;
    logic [COLOUR_BITS-1:0]  ram_wdata;
    logic [COLOUR_BITS-1:0]  ram_rdata;

    assign busy      = (state_q == CLEAR);
    assign rd_ready  = !busy;

    assign wr_addr   = xy_addr(x, y);
    assign rd_addr   = xy_addr(rd_x, rd_y);
    assign wr_en     = (state_q == RUN) && plot && in_range(x, y);
    assign rd_accept = rd_req && rd_ready;
    assign rd_en     = rd_accept && in_range(rd_x, rd_y);

    // The sweep owns the write port while it runs.
    assign ram_we    = (state_q == CLEAR) || wr_en;
    assign ram_waddr = (state_q == CLEAR) ? clr_addr_q : wr_addr;
    assign ram_wdata = (state_q == CLEAR) ? BG_COLOUR : colour;

    fb_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (COLOUR_BITS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            wr_dropped_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
            // The RAM read register is not reset; selecting a zero bypass
            // word makes rd_colour read 0 until the first real read.
            byp_q        <= 1'b1;
            byp_data_q   <= '0;
        end else begin
            wr_dropped_q <= plot && !wr_en;
            rd_valid_q   <= rd_accept;
            if (rd_accept) begin
                rd_oob_q   <= !in_range(rd_x, rd_y);
                byp_q      <= wr_en && (wr_addr == rd_addr);
                byp_data_q <= colour;
            end
            case (state_q)
                CLEAR: begin
                    if (clear) begin
                        clr_addr_q <= '0;
                    end else if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= RUN;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (clear) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign wr_dropped = wr_dropped_q;
    assign rd_valid   = rd_valid_q;
    assign rd_oob     = rd_oob_q;
    assign rd_colour  = rd_oob_q ? '0 : (byp_q ? byp_data_q : ram_rdata);

endmodule

// File: tb/tb_shadow_framebuffer.sv
module tb_shadow_framebuffer;
    import snake_pkg::*;

    localparam int SWEEP = 19200;
    localparam int LIMIT = 25000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       busy;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       wr_dropped;
    logic       rd_req = 1'b0;
    logic [7:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic       rd_ready;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic       rd_oob;

    int n_tests = 0;
    int n_fail  = 0;

    shadow_framebuffer #(
        .WIDTH       (160),
        .HEIGHT      (120),
        .COLOUR_BITS (3),
        .BG_COLOUR   (3'b000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .busy       (busy),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .wr_dropped (wr_dropped),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .rd_oob     (rd_oob)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] cx, input logic [6:0] cy,
                            input logic [2:0] exp_col, input logic exp_oob);
        rd_req = 1'b1;
        rd_x   = cx;
        rd_y   = cy;
        tick();
        rd_req = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_colour"}, 32'(rd_colour), 32'(exp_col));
        check({tag, "_oob"}, 32'(rd_oob), 32'(exp_oob));
    endtask

    task automatic plot_px(input logic [7:0] cx, input logic [6:0] cy, input logic [2:0] c);
        plot   = 1'b1;
        x      = cx;
        y      = cy;
        colour = c;
        tick();
        plot = 1'b0;
    endtask

    // Counts samples with busy high, starting at the current sample.
    // A read request is held throughout to show it is ignored; a plot is
    // optionally issued at cycle plot_at and must be dropped.
    task automatic measure_sweep(input string tag, input int plot_at);
        int cnt  = 0;
        bit seen = 1'b0;
        rd_req = 1'b1;
        rd_x   = 8'd0;
        rd_y   = 7'd0;
        while (busy === 1'b1 && cnt < LIMIT) begin
            if (rd_valid) seen = 1'b1;
            if (cnt == plot_at) begin
                plot = 1'b1; x = 8'd8; y = 7'd8; colour = 3'b111;
            end
            tick();
            cnt++;
            if (cnt == plot_at + 1) begin
                plot = 1'b0;
                check({tag, "_drop_mid"}, 32'(wr_dropped), 32'd1);
            end
        end
        rd_req = 1'b0;
        if (rd_valid) seen = 1'b1;
        check({tag, "_busy_len"}, cnt, SWEEP);
        check({tag, "_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        // Reset for three cycles
        reset = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(rd_ready), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_colour", 32'(rd_colour), 32'd0);
        check("rst_oob", 32'(rd_oob), 32'd0);
        check("rst_drop", 32'(wr_dropped), 32'd0);
        reset = 1'b0;
        measure_sweep("init", -10);
        check("init_ready", 32'(rd_ready), 32'd1);

        read_chk("rd_0_0", 8'd0, 7'd0, BLACK, 1'b0);
        read_chk("rd_159_119", 8'd159, 7'd119, BLACK, 1'b0);

        // Plain write then read
        plot_px(8'd10, 7'd20, RED);
        check("wr_ok_nodrop", 32'(wr_dropped), 32'd0);
        read_chk("rd_10_20", 8'd10, 7'd20, RED, 1'b0);
        read_chk("rd_11_20", 8'd11, 7'd20, BLACK, 1'b0);

        // Same-cycle write and read of one address
        plot = 1'b1; x = 8'd5; y = 7'd5; colour = GREEN;
        rd_req = 1'b1; rd_x = 8'd5; rd_y = 7'd5;
        tick();
        plot = 1'b0; rd_req = 1'b0;
        check("byp_valid", 32'(rd_valid), 32'd1);
        check("byp_colour", 32'(rd_colour), 32'(GREEN));
        read_chk("rd_5_5", 8'd5, 7'd5, GREEN, 1'b0);

        // Out-of-range writes
        plot_px(8'd160, 7'd0, 3'b111);
        check("drop_x", 32'(wr_dropped), 32'd1);
        plot_px(8'd0, 7'd120, 3'b111);
        check("drop_y", 32'(wr_dropped), 32'd1);
        tick();
        check("drop_end", 32'(wr_dropped), 32'd0);
        read_chk("rd_0_1", 8'd0, 7'd1, BLACK, 1'b0);
        read_chk("rd_0_0b", 8'd0, 7'd0, BLACK, 1'b0);

        // Out-of-range read, then result holds
        read_chk("rd_oob", 8'd200, 7'd50, 3'b000, 1'b1);
        tick();
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_oob", 32'(rd_oob), 32'd1);

        // Back-to-back reads
        rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd20;
        tick();
        rd_x = 8'd5; rd_y = 7'd5;
        check("b2b_1_col", 32'(rd_colour), 32'(RED));
        tick();
        rd_req = 1'b0;
        check("b2b_2_valid", 32'(rd_valid), 32'd1);
        check("b2b_2_col", 32'(rd_colour), 32'(GREEN));

        // Clear sweep with a plot issued mid-sweep
        plot_px(8'd7, 7'd7, 3'b001);
        read_chk("rd_7_7_pre", 8'd7, 7'd7, 3'b001, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        measure_sweep("clr", 100);
        read_chk("rd_7_7", 8'd7, 7'd7, BLACK, 1'b0);
        read_chk("rd_8_8", 8'd8, 7'd8, BLACK, 1'b0);

        // Reset part way through a sweep restarts it
        plot_px(8'd1, 7'd2, RED);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5000) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        measure_sweep("rst_mid", -10);
        read_chk("rd_1_2", 8'd1, 7'd2, BLACK, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
